uart_tx: RTL and testbench

UART transmitter: serializes one parallel byte per request into an asynchronous frame (start bit, 8 data bits LSB first, optional even/odd parity bit, stop bit) on a single line. It is the transmit-side counterpart of the UART receive path and uses the same parity conventions, so a looped-back line is accepted by the receiver with `par_err` = 0. It sits between the system's byte-producing logic and the serial pad.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_parity_calc.sv | 12 +
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity type encodings and frame size.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even parity is the XOR of the data bits, odd is its complement.
module parity_calc
   import uart_pkg::*;
(
   input  logic [7:0] data,
   input  logic       par_type,
   output logic       par_bit
);

   assign par_bit = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Handshake: a request is taken on any rising edge where data_valid = 1 and the FSM is IDLE; otherwise it is dropped.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] P_Data,
   input  logic       data_valid,
   input  logic       par_en,
   input  logic       PAR_TYPE,
   output logic       tx_out,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t   state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic             tx_n, busy_n;
   logic             load;
   logic             bit_done;

   logic [7:0]       data_q;
   logic             par_en_q;
   logic             par_q;
   logic             par_calc;

   parity_calc u_parity (
      .data     (P_Data),
      .par_type (PAR_TYPE),
      .par_bit  (par_calc)
   );

   assign bit_done = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         tx_out <= 1'b1;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         tx_out <= tx_n;
         busy   <= busy_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
      end else if (load) begin
         data_q   <= P_Data;
         par_en_q <= par_en;
         par_q    <= par_calc;
      end
   end

   // Outputs are computed for the next state so tx_out/busy change on the same edge as the state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      tx_n    = tx_out;
      busy_n  = busy;
      load    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n  = '0;
            idx_n  = '0;
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (data_valid) begin
               load    = 1'b1;
               state_n = START;
               tx_n    = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               cnt_n   = '0;
               state_n = DATA;
               tx_n    = data_q[0];
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_n = '0;
               if (idx == LAST_IDX) begin
                  idx_n = '0;
                  if (par_en_q) begin
                     state_n = PARITY;
                     tx_n    = par_q;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  idx_n = idx + 3'd1;
                  tx_n  = data_q[idx + 3'd1];
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_done) begin
               cnt_n   = '0;
               state_n = STOP;
               tx_n    = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               cnt_n   = '0;
               state_n = IDLE;
               tx_n    = 1'b1;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with one instance at CLKS_PER_BIT = 1 and one at 16.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] pd1 = 8'h00;
   logic       dv1 = 1'b0, pe1 = 1'b0, pt1 = 1'b0;
   logic       tx1, busy1;

   logic [7:0] pd16 = 8'h00;
   logic       dv16 = 1'b0, pe16 = 1'b0, pt16 = 1'b0;
   logic       tx16, busy16;

   int compared   = 0;
   int mismatched = 0;
   int busy_cnt   = 0;

   logic [1:0] exp_q[$];
   logic       tx_log[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   uart_tx #(.CLKS_PER_BIT(1)) u_tx1 (
      .clk        (clk),
      .rst        (rst),
      .P_Data     (pd1),
      .data_valid (dv1),
      .par_en     (pe1),
      .PAR_TYPE   (pt1),
      .tx_out     (tx1),
      .busy       (busy1)
   );

   uart_tx #(.CLKS_PER_BIT(16)) u_tx16 (
      .clk        (clk),
      .rst        (rst),
      .P_Data     (pd16),
      .data_valid (dv16),
      .par_en     (pe16),
      .PAR_TYPE   (pt16),
      .tx_out     (tx16),
      .busy       (busy16)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [7:0] d, input logic pe, input logic pt, input bit hold);
      pd1 = d; pe1 = pe; pt1 = pt; dv1 = 1'b1;
      tick();
      if (!hold) dv1 = 1'b0;
   endtask

   task automatic send16(input logic [7:0] d, input logic pe, input logic pt);
      pd16 = d; pe16 = pe; pt16 = pt; dv16 = 1'b1;
      tick();
      dv16 = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Expected {busy, tx} per cycle, followed by one idle cycle.
   task automatic push_frame(input int cpb, input logic [7:0] d, input logic pe, input logic par);
      for (int c = 0; c < cpb; c++) exp_q.push_back(2'b10);
      for (int b = 0; b < 8; b++)
         for (int c = 0; c < cpb; c++) exp_q.push_back({1'b1, d[b]});
      if (pe)
         for (int c = 0; c < cpb; c++) exp_q.push_back({1'b1, par});
      for (int c = 0; c < cpb; c++) exp_q.push_back(2'b11);
      exp_q.push_back(2'b01);
   endtask

   task automatic drain(input bit sel, input string tag, input int chg_at,
                        input logic [7:0] new_d, input int drop_at);
      int i;
      logic [1:0] e;
      logic [1:0] obs;
      i = 0;
      busy_cnt = 0;
      tx_log.delete();
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = sel ? {busy16, tx16} : {busy1, tx1};
         chk($sformatf("%s[%0d]", tag, i), {6'b0, obs}, {6'b0, e});
         if (obs[1]) busy_cnt++;
         tx_log.push_back(obs[0]);
         if (i == chg_at) pd1 = new_d;
         if (i == drop_at) dv1 = 1'b0;
         tick();
         i++;
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [7:0] rx_byte;
   logic       rx_par;

   initial begin
      tick();
      tick();
      chk("rst_high_tx1",   {7'b0, tx1},    8'h01);
      chk("rst_high_busy1", {7'b0, busy1},  8'h00);
      chk("rst_high_tx16",  {7'b0, tx16},   8'h01);
      chk("rst_high_busy16",{7'b0, busy16}, 8'h00);
      rst = 1'b0;
      tick();
      tick();
      chk("rst_rel_tx1",   {7'b0, tx1},    8'h01);
      chk("rst_rel_busy1", {7'b0, busy1},  8'h00);
      chk("rst_rel_tx16",  {7'b0, tx16},   8'h01);
      chk("rst_rel_busy16",{7'b0, busy16}, 8'h00);

      // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 then idle
      push_frame(1, 8'hA5, 1'b0, 1'b0);
      send1(8'hA5, 1'b0, 1'b0, 1'b0);
      drain(1'b0, "a5_nopar", -1, 8'h00, -1);
      chk("a5_nopar_busy", 8'(busy_cnt), 8'd10);

      // 0xA5 even parity -> 0, odd parity -> 1
      push_frame(1, 8'hA5, 1'b1, 1'b0);
      send1(8'hA5, 1'b1, 1'b0, 1'b0);
      drain(1'b0, "a5_even", -1, 8'h00, -1);
      chk("a5_even_busy", 8'(busy_cnt), 8'd11);
      chk("a5_even_par", {7'b0, tx_log[9]}, 8'h00);

      push_frame(1, 8'hA5, 1'b1, 1'b1);
      send1(8'hA5, 1'b1, 1'b1, 1'b0);
      drain(1'b0, "a5_odd", -1, 8'h00, -1);
      chk("a5_odd_par", {7'b0, tx_log[9]}, 8'h01);

      // Reset mid-DATA, then a clean 0x3C even-parity frame
      send1(8'hA5, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_tx",   {7'b0, tx1},   8'h01);
      chk("midrst_busy", {7'b0, busy1}, 8'h00);
      rst = 1'b0;
      tick();
      chk("post_rst_idle", {6'b0, busy1, tx1}, 8'h01);
      push_frame(1, 8'h3C, 1'b1, 1'b0);
      send1(8'h3C, 1'b1, 1'b0, 1'b0);
      drain(1'b0, "post_rst_3c", -1, 8'h00, -1);

      // CLKS_PER_BIT = 16, 0x00 odd parity
      push_frame(16, 8'h00, 1'b1, 1'b1);
      send16(8'h00, 1'b1, 1'b1);
      drain(1'b1, "c16_00_odd", -1, 8'h00, -1);
      chk("c16_busy_lo", 8'(busy_cnt), 8'(176 & 8'hFF));
      chk("c16_busy_hi", 8'(busy_cnt >> 8), 8'(176 >> 8));
      // Receiver model: mid-bit sampling of the captured line
      for (int b = 0; b < 8; b++) rx_byte[b] = tx_log[16 * (b + 1) + 8];
      rx_par = tx_log[16 * 9 + 8];
      chk("c16_rx_start", {7'b0, tx_log[8]}, 8'h00);
      chk("c16_rx_byte", rx_byte, 8'h00);
      chk("c16_rx_par", {7'b0, rx_par}, 8'h01);
      chk("c16_rx_par_err", {7'b0, ~(^{rx_byte, rx_par})}, 8'h00);
      chk("c16_rx_stop", {7'b0, tx_log[16 * 10 + 8]}, 8'h01);

      // Back-to-back with data_valid held: 0xFF then 0x3C, even parity 0 and 0
      push_frame(1, 8'hFF, 1'b1, 1'b0);
      push_frame(1, 8'h3C, 1'b1, 1'b0);
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b01);
      send1(8'hFF, 1'b1, 1'b0, 1'b1);
      drain(1'b0, "b2b", 3, 8'h3C, 12);
      chk("b2b_par1", {7'b0, tx_log[9]}, 8'h00);
      chk("b2b_gap",  {7'b0, tx_log[11]}, 8'h01);
      chk("b2b_par2", {7'b0, tx_log[21]}, 8'h00);
      chk("b2b_busy", 8'(busy_cnt), 8'd22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
